// File: rtl/pca9685_register_bank.sv
// PCA9685-compatible register file driven by an I2C target's pointer/write/read strobes.
// LED words are written to a shadow copy and reloaded into the active copy on STOP or per-write (OCH).
module pca9685_register_bank #(
    parameter int unsigned NUM_CH         = 16,
    parameter logic [7:0]  PRESCALE_RESET = 8'h1E
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ptr_load_i,
    input  logic [7:0]           ptr_addr_i,
    input  logic                 wr_valid_i,
    input  logic [7:0]           wr_data_i,
    input  logic                 rd_req_i,
    output logic [7:0]           rd_data_o,
    output logic                 rd_valid_o,
    input  logic                 stop_i,
    output logic [7:0]           mode1_o,
    output logic [7:0]           mode2_o,
    output logic [7:0]           prescale_o,
    output logic [NUM_CH*13-1:0] led_on_o,
    output logic [NUM_CH*13-1:0] led_off_o,
    output logic                 led_update_o
);
    localparam logic [12:0] ON_RESET  = 13'h0000;
    localparam logic [12:0] OFF_RESET = 13'h1000;

    logic [7:0]  mode1_q, mode1_d;
    logic [4:0]  mode2_q, mode2_d;
    logic [7:0]  subadr_q [3];
    logic [7:0]  subadr_d [3];
    logic [7:0]  allcall_q, allcall_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        upd_q, upd_d;
    logic        och_pend_q, och_pend_d;
    // Each LED word is {full, count[11:0]}: H register bits[4:0] map onto word[12:8].
    logic [12:0] sh_on_q  [NUM_CH];
    logic [12:0] sh_on_d  [NUM_CH];
    logic [12:0] sh_off_q [NUM_CH];
    logic [12:0] sh_off_d [NUM_CH];
    logic [12:0] act_on_q  [NUM_CH];
    logic [12:0] act_on_d  [NUM_CH];
    logic [12:0] act_off_q [NUM_CH];
    logic [12:0] act_off_d [NUM_CH];

    logic        do_wr, do_rd, in_led, led_wr, reload;
    logic [7:0]  led_idx, rd_mux;

    always_comb begin
        do_wr   = wr_valid_i && !ptr_load_i;
        do_rd   = rd_req_i && !ptr_load_i && !wr_valid_i;
        led_idx = ptr_q - 8'h06;
        in_led  = (ptr_q >= 8'h06) && (ptr_q <= 8'h45);

        mode1_d    = mode1_q;
        mode2_d    = mode2_q;
        subadr_d   = subadr_q;
        allcall_d  = allcall_q;
        prescale_d = prescale_q;
        sh_on_d    = sh_on_q;
        sh_off_d   = sh_off_q;
        led_wr     = 1'b0;

        if (do_wr) begin
            case (ptr_q)
                8'h00: mode1_d = {1'b0, wr_data_i[6:0]};
                8'h01: mode2_d = wr_data_i[4:0];
                8'h02: subadr_d[0] = wr_data_i;
                8'h03: subadr_d[1] = wr_data_i;
                8'h04: subadr_d[2] = wr_data_i;
                8'h05: allcall_d = wr_data_i;
                8'hFA, 8'hFB, 8'hFC, 8'hFD: begin
                    led_wr = 1'b1;
                    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                        case (ptr_q[1:0])
                            2'd2:    sh_on_d[ch][7:0]   = wr_data_i;
                            2'd3:    sh_on_d[ch][12:8]  = wr_data_i[4:0];
                            2'd0:    sh_off_d[ch][7:0]  = wr_data_i;
                            default: sh_off_d[ch][12:8] = wr_data_i[4:0];
                        endcase
                    end
                end
                8'hFE: begin
                    if (mode1_q[4])
                        prescale_d = (wr_data_i < 8'd3) ? 8'd3 : wr_data_i;
                end
                default: begin
                    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                        if (in_led && led_idx[7:2] == 6'(ch)) begin
                            led_wr = 1'b1;
                            case (led_idx[1:0])
                                2'd0:    sh_on_d[ch][7:0]   = wr_data_i;
                                2'd1:    sh_on_d[ch][12:8]  = wr_data_i[4:0];
                                2'd2:    sh_off_d[ch][7:0]  = wr_data_i;
                                default: sh_off_d[ch][12:8] = wr_data_i[4:0];
                            endcase
                        end
                    end
                end
            endcase
        end

        rd_mux = '0;
        case (ptr_q)
            8'h00: rd_mux = mode1_q;
            8'h01: rd_mux = {3'b000, mode2_q};
            8'h02: rd_mux = subadr_q[0];
            8'h03: rd_mux = subadr_q[1];
            8'h04: rd_mux = subadr_q[2];
            8'h05: rd_mux = allcall_q;
            8'hFE: rd_mux = prescale_q;
            default: begin
                for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                    if (in_led && led_idx[7:2] == 6'(ch)) begin
                        case (led_idx[1:0])
                            2'd0:    rd_mux = sh_on_q[ch][7:0];
                            2'd1:    rd_mux = {3'b000, sh_on_q[ch][12:8]};
                            2'd2:    rd_mux = sh_off_q[ch][7:0];
                            default: rd_mux = {3'b000, sh_off_q[ch][12:8]};
                        endcase
                    end
                end
            end
        endcase

        rd_data_d  = do_rd ? rd_mux : rd_data_q;
        rd_valid_d = do_rd;

        ptr_d = ptr_q;
        if (ptr_load_i)
            ptr_d = ptr_addr_i;
        else if ((do_wr || do_rd) && mode1_q[5])
            ptr_d = ptr_q + 8'd1;

        // OCH=1 reloads on the cycle after the shadow write lands, so it copies the settled shadow.
        och_pend_d = led_wr && mode2_q[3];
        reload     = (stop_i && !mode2_q[3]) || och_pend_q;
        upd_d      = reload;
        act_on_d   = reload ? sh_on_q  : act_on_q;
        act_off_d  = reload ? sh_off_q : act_off_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode1_q     <= 8'h11;
            mode2_q     <= 5'h04;
            subadr_q[0] <= 8'hE2;
            subadr_q[1] <= 8'hE4;
            subadr_q[2] <= 8'hE8;
            allcall_q   <= 8'hE0;
            prescale_q  <= PRESCALE_RESET;
            ptr_q       <= 8'h00;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            upd_q       <= 1'b0;
            och_pend_q  <= 1'b0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                sh_on_q[ch]   <= ON_RESET;
                sh_off_q[ch]  <= OFF_RESET;
                act_on_q[ch]  <= ON_RESET;
                act_off_q[ch] <= OFF_RESET;
            end
        end else begin
            mode1_q    <= mode1_d;
            mode2_q    <= mode2_d;
            subadr_q   <= subadr_d;
            allcall_q  <= allcall_d;
            prescale_q <= prescale_d;
            ptr_q      <= ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            upd_q      <= upd_d;
            och_pend_q <= och_pend_d;
            sh_on_q    <= sh_on_d;
            sh_off_q   <= sh_off_d;
            act_on_q   <= act_on_d;
            act_off_q  <= act_off_d;
        end
    end

    always_comb begin
        led_on_o  = '0;
        led_off_o = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            led_on_o[ch*13 +: 13]  = act_on_q[ch];
            led_off_o[ch*13 +: 13] = act_off_q[ch];
        end
    end

    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign mode1_o      = mode1_q;
    assign mode2_o      = {3'b000, mode2_q};
    assign prescale_o   = prescale_q;
    assign led_update_o = upd_q;

endmodule

// File: tb/tb_pca9685_register_bank.sv
// Self-checking bench for pca9685_register_bank: read data is scoreboarded through a queue
// popped whenever the DUT raises rd_valid_o; everything else is compared inline per scenario.
module tb_pca9685_register_bank;
    localparam int unsigned NCH = 16;
    localparam int unsigned W   = NCH * 13;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         ptr_load_i = 1'b0;
    logic [7:0]   ptr_addr_i = '0;
    logic         wr_valid_i = 1'b0;
    logic [7:0]   wr_data_i = '0;
    logic         rd_req_i = 1'b0;
    logic         stop_i = 1'b0;
    logic [7:0]   rd_data_o;
    logic         rd_valid_o;
    logic [7:0]   mode1_o, mode2_o, prescale_o;
    logic [W-1:0] led_on_o, led_off_o;
    logic         led_update_o;

    int           tests = 0;
    int           fails = 0;
    int           upd_cnt = 0;
    logic [7:0]   exp_q [$];
    logic [W-1:0] all_off, all_zero;

    pca9685_register_bank #(.NUM_CH(NCH), .PRESCALE_RESET(8'h1E)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ptr_load_i(ptr_load_i), .ptr_addr_i(ptr_addr_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
        .rd_req_i(rd_req_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .stop_i(stop_i),
        .mode1_o(mode1_o), .mode2_o(mode2_o), .prescale_o(prescale_o),
        .led_on_o(led_on_o), .led_off_o(led_off_o), .led_update_o(led_update_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard consumer: every read strobe from the DUT must match the oldest expectation.
    always @(negedge clk_i) begin
        if (led_update_o) upd_cnt++;
        if (rd_valid_o) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_spurious: got rd_valid_o with data %02h, required no read", rd_data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data_o !== e) begin
                    fails++;
                    $display("FAIL rd_data: got %02h, required %02h", rd_data_o, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ptr(input logic [7:0] a);
        ptr_load_i = 1'b1;
        ptr_addr_i = a;
        tick();
        ptr_load_i = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        set_ptr(a);
        wr_byte(d);
    endtask

    task automatic rd_byte(input logic [7:0] e);
        exp_q.push_back(e);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        tick();
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        tests++;
        if (mode1_o !== 8'h11) begin fails++; $display("FAIL reset_mode1: got %02h, required 11", mode1_o); end
        tests++;
        if (mode2_o !== 8'h04) begin fails++; $display("FAIL reset_mode2: got %02h, required 04", mode2_o); end
        tests++;
        if (prescale_o !== 8'h1E) begin fails++; $display("FAIL reset_prescale: got %02h, required 1e", prescale_o); end
        tests++;
        if (led_off_o !== all_off) begin fails++; $display("FAIL reset_led_off: got %h, required %h", led_off_o, all_off); end
        tests++;
        if (led_on_o !== all_zero) begin fails++; $display("FAIL reset_led_on: got %h, required 0", led_on_o); end
        tests++;
        if (rd_valid_o !== 1'b0 || led_update_o !== 1'b0) begin
            fails++; $display("FAIL reset_strobes: got rd_valid=%b upd=%b, required 0 0", rd_valid_o, led_update_o);
        end
        rd_byte(8'h11);
        set_ptr(8'h02);
        rd_byte(8'hE2);
        set_ptr(8'h05);
        rd_byte(8'hE0);
    endtask

    task automatic test_led_write();
        int u0;
        wr_reg(8'h00, 8'h20);
        tests++;
        if (mode1_o !== 8'h20) begin fails++; $display("FAIL ai_mode1: got %02h, required 20", mode1_o); end
        set_ptr(8'h06);
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
        u0 = upd_cnt;
        pulse_stop();
        tests++;
        if (led_on_o[12:0] !== 13'h0211) begin fails++; $display("FAIL led0_on: got %h, required 0211", led_on_o[12:0]); end
        tests++;
        if (led_off_o[12:0] !== 13'h0433) begin fails++; $display("FAIL led0_off: got %h, required 0433", led_off_o[12:0]); end
        tests++;
        if (upd_cnt - u0 !== 1) begin fails++; $display("FAIL led_update_count: got %0d, required 1", upd_cnt - u0); end
        set_ptr(8'h06);
        rd_byte(8'h11); rd_byte(8'h02); rd_byte(8'h33); rd_byte(8'h04);
    endtask

    task automatic test_och0_hold();
        int u0;
        u0 = upd_cnt;
        wr_reg(8'h0A, 8'h55);
        repeat (3) tick();
        tests++;
        if (led_on_o[25:13] !== 13'h0000 || upd_cnt != u0) begin
            fails++; $display("FAIL och0_hold: got on=%h pulses=%0d, required 0000 0", led_on_o[25:13], upd_cnt - u0);
        end
        pulse_stop();
        tests++;
        if (led_on_o[25:13] !== 13'h0055 || upd_cnt - u0 !== 1) begin
            fails++; $display("FAIL och0_stop: got on=%h pulses=%0d, required 0055 1", led_on_o[25:13], upd_cnt - u0);
        end
    endtask

    task automatic test_prescale();
        wr_reg(8'hFE, 8'h79);
        tests++;
        if (prescale_o !== 8'h1E) begin fails++; $display("FAIL prescale_awake: got %02h, required 1e", prescale_o); end
        wr_reg(8'h00, 8'hB0);
        tests++;
        if (mode1_o !== 8'h30) begin fails++; $display("FAIL restart_bit: got %02h, required 30", mode1_o); end
        wr_reg(8'hFE, 8'h79);
        tests++;
        if (prescale_o !== 8'h79) begin fails++; $display("FAIL prescale_sleep: got %02h, required 79", prescale_o); end
        wr_reg(8'hFE, 8'h01);
        tests++;
        if (prescale_o !== 8'h03) begin fails++; $display("FAIL prescale_clamp: got %02h, required 03", prescale_o); end
        set_ptr(8'hFE);
        rd_byte(8'h03);
    endtask

    task automatic test_ai_wrap();
        set_ptr(8'hFF);
        rd_byte(8'h00);
        rd_byte(8'h30);
    endtask

    task automatic test_ai_off();
        wr_reg(8'h00, 8'h10);
        set_ptr(8'h06);
        rd_byte(8'h11);
        rd_byte(8'h11);
    endtask

    task automatic test_all_led();
        wr_reg(8'h00, 8'h20);
        set_ptr(8'hFA);
        wr_byte(8'h00); wr_byte(8'h00); wr_byte(8'h00); wr_byte(8'h10);
        pulse_stop();
        tests++;
        if (led_off_o !== all_off) begin fails++; $display("FAIL all_led_off: got %h, required %h", led_off_o, all_off); end
        tests++;
        if (led_on_o !== all_zero) begin fails++; $display("FAIL all_led_on: got %h, required 0", led_on_o); end
        set_ptr(8'hFD);
        rd_byte(8'h00);
        set_ptr(8'h08);
        rd_byte(8'h00);
    endtask

    task automatic test_och1();
        wr_reg(8'h01, 8'hEC);
        tests++;
        if (mode2_o !== 8'h0C) begin fails++; $display("FAIL mode2_mask: got %02h, required 0c", mode2_o); end
        set_ptr(8'h0E);
        wr_byte(8'h77);
        tests++;
        if (led_on_o[38:26] !== 13'h0000) begin fails++; $display("FAIL och1_early: got %h, required 0000", led_on_o[38:26]); end
        tick();
        tests++;
        if (led_on_o[38:26] !== 13'h0077 || led_update_o !== 1'b1) begin
            fails++; $display("FAIL och1_reload: got on=%h upd=%b, required 0077 1", led_on_o[38:26], led_update_o);
        end
        wr_reg(8'h01, 8'h04);
    endtask

    task automatic test_priority();
        ptr_load_i = 1'b1; ptr_addr_i = 8'h02;
        wr_valid_i = 1'b1; wr_data_i = 8'h55;
        tick();
        ptr_load_i = 1'b0; wr_valid_i = 1'b0;
        rd_byte(8'hE2);
        set_ptr(8'h03);
        wr_valid_i = 1'b1; wr_data_i = 8'h66; rd_req_i = 1'b1;
        tick();
        wr_valid_i = 1'b0; rd_req_i = 1'b0;
        tick();
        set_ptr(8'h03);
        rd_byte(8'h66);
        ptr_load_i = 1'b1; ptr_addr_i = 8'h05; rd_req_i = 1'b1;
        tick();
        ptr_load_i = 1'b0; rd_req_i = 1'b0;
        tick();
        rd_byte(8'hE0);
        wr_reg(8'h50, 8'hAA);
        set_ptr(8'h50);
        rd_byte(8'h00);
    endtask

    task automatic test_reset_mid();
        set_ptr(8'h00);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        rst_i = 1'b1;
        #1;
        tests++;
        if (rd_valid_o !== 1'b0) begin fails++; $display("FAIL reset_cancel_rd: got %b, required 0", rd_valid_o); end
        tests++;
        if (mode1_o !== 8'h11 || prescale_o !== 8'h1E || led_on_o !== all_zero) begin
            fails++; $display("FAIL reset_mid_state: got mode1=%02h pre=%02h, required 11 1e", mode1_o, prescale_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            all_off[i*13 +: 13]  = 13'h1000;
            all_zero[i*13 +: 13] = 13'h0000;
        end
        test_reset();
        test_led_write();
        test_och0_hold();
        test_prescale();
        test_ai_wrap();
        test_ai_off();
        test_all_led();
        test_och1();
        test_priority();
        test_reset_mid();
        repeat (2) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL rd_missing: got %0d undelivered reads, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
